// File: rtl/p405s_dcu_bist_pkg.sv
// Shared types for the DCU tag SRAM March C- BIST: element/op/state enums and
// the per-element direction and op table.
package p405s_dcu_bist_pkg;

  typedef enum logic [2:0] {M0 = 3'd0, M1, M2, M3, M4, M5} marchElem_t;
  typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} marchOp_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} bistState_t;

  localparam marchElem_t LAST_ELEM = M5;

  // M3..M5 walk the address space downwards, the rest upwards
  function automatic logic elemIsDown(input marchElem_t e);
    return (e == M3) || (e == M4) || (e == M5);
  endfunction

  function automatic logic elemHasTwoOps(input marchElem_t e);
    return (e == M1) || (e == M2) || (e == M3) || (e == M4);
  endfunction

  function automatic marchOp_t elemOp(input marchElem_t e, input logic opIdx);
    marchOp_t op;
    case (e)
      M0:      op = OP_W0;
      M1, M3:  op = opIdx ? OP_W1 : OP_R0;
      M2, M4:  op = opIdx ? OP_W0 : OP_R1;
      default: op = OP_R0;
    endcase
    return op;
  endfunction

  function automatic logic opIsRead(input marchOp_t op);
    return (op == OP_R0) || (op == OP_R1);
  endfunction

  function automatic logic opIsOnes(input marchOp_t op);
    return (op == OP_W1) || (op == OP_R1);
  endfunction

endpackage

// File: rtl/p405s_dcu_bist_cmp.sv
// Read-compare stage: holds the expected word for one cycle while the SRAM
// produces Q, then flags a miscompare and latches the first failure only.
module p405s_dcu_bist_cmp
  import p405s_dcu_bist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              clear,
  input  logic              rdValid,
  input  logic [DATA_W-1:0] rdExp,
  input  logic [ADDR_W-1:0] rdAddr,
  input  marchElem_t        rdElem,
  input  logic [DATA_W-1:0] rdData,
  output logic              miss,
  output logic              fail,
  output logic [ADDR_W-1:0] failAddr,
  output logic [2:0]        failElem,
  output logic [DATA_W-1:0] failBits
);

  logic              pendValid;
  logic [DATA_W-1:0] pendExp;
  logic [ADDR_W-1:0] pendAddr;
  marchElem_t        pendElem;
  logic [DATA_W-1:0] diff;

  assign diff = rdData ^ pendExp;
  assign miss = pendValid && (diff != '0);

  always_ff @(posedge cclk) begin
    if (reset || clear) begin
      pendValid <= 1'b0;
      pendExp   <= '0;
      pendAddr  <= '0;
      pendElem  <= M0;
    end else begin
      pendValid <= rdValid;
      pendExp   <= rdExp;
      pendAddr  <= rdAddr;
      pendElem  <= rdElem;
    end
  end

  // Later miscompares never overwrite the first capture
  always_ff @(posedge cclk) begin
    if (reset || clear) begin
      fail     <= 1'b0;
      failAddr <= '0;
      failElem <= '0;
      failBits <= '0;
    end else if (miss && !fail) begin
      fail     <= 1'b1;
      failAddr <= pendAddr;
      failElem <= pendElem;
      failBits <= diff;
    end
  end

endmodule

// File: rtl/p405s_dcu_tagsram_bist_ctl.sv
// March C- BIST controller for the DCU tag SRAM: sequences one op per cycle
// onto the registered SRAM BIST port and reports first-failure information.
module p405s_dcu_tagsram_bist_ctl
  import p405s_dcu_bist_pkg::*;
#(
  parameter int              ADDR_W       = 8,
  parameter int              DATA_W       = 48,
  parameter int              DEPTH        = 256,
  parameter logic [DATA_W-1:0] BG_PATTERN = '0,
  parameter bit              STOP_ON_FAIL = 1'b1
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              bist_start,
  output logic              bist_mode,
  output logic              bist_ce_n,
  output logic              bist_we_n,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_wr_data,
  input  logic [DATA_W-1:0] bist_rd_data,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic [2:0]        bist_fail_elem,
  output logic [DATA_W-1:0] bist_fail_bits
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  bistState_t        state, stateNext;
  marchElem_t        elem, nElem, issueElem;
  logic              opIdx, nOpIdx, issueOpIdx;
  logic [ADDR_W-1:0] addrReg, nAddr, issueAddr;
  logic              runLast, issue, cmpMiss, abort, startAccept;
  marchOp_t          issueOp;
  logic [DATA_W-1:0] issueData, wrDataReg, rdExpReg;
  logic              ceNReg, weNReg;

  assign startAccept = bist_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign abort       = STOP_ON_FAIL && cmpMiss;

  always_ff @(posedge cclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE, ST_DONE: if (bist_start) stateNext = ST_RUN;
      ST_RUN:           if (abort || runLast) stateNext = ST_DRAIN;
      ST_DRAIN:         stateNext = ST_DONE;
      default:          stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    bist_mode = 1'b0;
    bist_busy = 1'b0;
    bist_done = 1'b0;
    case (state)
      ST_RUN, ST_DRAIN: begin
        bist_mode = 1'b1;
        bist_busy = 1'b1;
      end
      ST_DONE: bist_done = 1'b1;
      default: ;
    endcase
  end

  // Successor of the op currently on the pins; runLast marks the final M5 read
  always_comb begin
    nElem   = elem;
    nOpIdx  = opIdx;
    nAddr   = addrReg;
    runLast = 1'b0;
    if (elemHasTwoOps(elem) && !opIdx) begin
      nOpIdx = 1'b1;
    end else begin
      nOpIdx = 1'b0;
      if (elemIsDown(elem) ? (addrReg != '0) : (addrReg != ADDR_LAST)) begin
        nAddr = elemIsDown(elem) ? addrReg - ADDR_W'(1) : addrReg + ADDR_W'(1);
      end else if (elem == LAST_ELEM) begin
        runLast = 1'b1;
      end else begin
        nElem = marchElem_t'(3'(elem) + 3'd1);
        nAddr = elemIsDown(nElem) ? ADDR_LAST : '0;
      end
    end
  end

  always_comb begin
    issue      = 1'b0;
    issueElem  = M0;
    issueOpIdx = 1'b0;
    issueAddr  = '0;
    if (startAccept) begin
      issue = 1'b1;
    end else if ((state == ST_RUN) && !abort && !runLast) begin
      issue      = 1'b1;
      issueElem  = nElem;
      issueOpIdx = nOpIdx;
      issueAddr  = nAddr;
    end
  end

  assign issueOp   = elemOp(issueElem, issueOpIdx);
  assign issueData = opIsOnes(issueOp) ? ~BG_PATTERN : BG_PATTERN;

  // Write data only moves on writes so the pins hold the last written word
  always_ff @(posedge cclk) begin
    if (reset) begin
      ceNReg    <= 1'b1;
      weNReg    <= 1'b1;
      addrReg   <= '0;
      wrDataReg <= '0;
      rdExpReg  <= '0;
      elem      <= M0;
      opIdx     <= 1'b0;
    end else if (issue) begin
      ceNReg  <= 1'b0;
      weNReg  <= opIsRead(issueOp);
      addrReg <= issueAddr;
      elem    <= issueElem;
      opIdx   <= issueOpIdx;
      if (opIsRead(issueOp)) rdExpReg  <= issueData;
      else                   wrDataReg <= issueData;
    end else begin
      ceNReg <= 1'b1;
      weNReg <= 1'b1;
    end
  end

  assign bist_ce_n    = ceNReg;
  assign bist_we_n    = weNReg;
  assign bist_addr    = addrReg;
  assign bist_wr_data = wrDataReg;

  p405s_dcu_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) cmp (
    .cclk     (cclk),
    .reset    (reset),
    .clear    (startAccept),
    .rdValid  (~ceNReg & weNReg),
    .rdExp    (rdExpReg),
    .rdAddr   (addrReg),
    .rdElem   (elem),
    .rdData   (bist_rd_data),
    .miss     (cmpMiss),
    .fail     (bist_fail),
    .failAddr (bist_fail_addr),
    .failElem (bist_fail_elem),
    .failBits (bist_fail_bits)
  );

endmodule

// File: tb/tb_p405s_dcu_tagsram_bist_ctl.sv
// Bench for the tag SRAM BIST controller: three instances (default, no-stop,
// alternate background) each driving a behavioural 256x48 SRAM with faults.
module tb_p405s_dcu_tagsram_bist_ctl;

  localparam int NDUT = 3;

  logic cclk = 1'b0;
  logic reset;
  logic [NDUT-1:0]       start, mode, ceN, weN, busy, done, fail;
  logic [NDUT-1:0][7:0]  addr, failAddr;
  logic [NDUT-1:0][2:0]  failElem;
  logic [NDUT-1:0][47:0] wrData, rdData, failBits;
  logic [47:0] mem [NDUT][256];

  int faultMode, sel, applied, errs;
  int busyCnt, ceCnt, wrCnt;

  typedef struct packed {
    logic [7:0]  addr;
    logic        weN;
    logic [47:0] wd;
  } opExp_t;
  opExp_t expQ[$];
  opExp_t gotOp, expOp;

  always #5 cclk = ~cclk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    p405s_dcu_tagsram_bist_ctl #(
      .ADDR_W      (8),
      .DATA_W      (48),
      .DEPTH       (256),
      .BG_PATTERN  (g == 2 ? 48'hAAAA_AAAA_AAAA : 48'h0),
      .STOP_ON_FAIL(g == 1 ? 1'b0 : 1'b1)
    ) dut (
      .cclk          (cclk),
      .reset         (reset),
      .bist_start    (start[g]),
      .bist_mode     (mode[g]),
      .bist_ce_n     (ceN[g]),
      .bist_we_n     (weN[g]),
      .bist_addr     (addr[g]),
      .bist_wr_data  (wrData[g]),
      .bist_rd_data  (rdData[g]),
      .bist_busy     (busy[g]),
      .bist_done     (done[g]),
      .bist_fail     (fail[g]),
      .bist_fail_addr(failAddr[g]),
      .bist_fail_elem(failElem[g]),
      .bist_fail_bits(failBits[g])
    );
  end

  // Synchronous SRAM model; faultMode 1 = bit5 of 0x3C stuck-at-1,
  // faultMode 2 = any write to 0x00 flips bit0 of 0xFF
  always @(posedge cclk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (ceN[i] === 1'b0) begin
        if (weN[i] === 1'b0) begin
          mem[i][addr[i]] <= wrData[i];
          if (faultMode == 2 && addr[i] == 8'h00) mem[i][8'hFF][0] <= ~mem[i][8'hFF][0];
        end else begin
          rdData[i] <= mem[i][addr[i]] | ((faultMode == 1 && addr[i] == 8'h3C) ? 48'h20 : 48'h0);
        end
      end
    end
  end

  // Scoreboard pop: every enabled SRAM cycle must match the next expected op
  always @(negedge cclk) begin
    if (!reset) begin
      if (busy[sel] === 1'b1) busyCnt++;
      if (ceN[sel] === 1'b0) begin
        ceCnt++;
        if (weN[sel] === 1'b0) wrCnt++;
        applied++;
        gotOp = opExp_t'({addr[sel], weN[sel], wrData[sel]});
        if (expQ.size() == 0) begin
          errs++;
          $display("[TB] FAIL op_stream: unexpected op got %h expected none", gotOp);
        end else begin
          expOp = expQ.pop_front();
          if (gotOp !== expOp) begin
            errs++;
            $display("[TB] FAIL op_stream: got %h expected %h", gotOp, expOp);
          end
        end
      end
    end
  end

  task automatic pushRun(input logic [47:0] bg);
    logic [47:0] lw;
    lw = '0;
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < 256; s++) begin
        logic [7:0] a;
        int nops;
        a = (e < 3) ? 8'(s) : 8'(255 - s);
        nops = (e == 0 || e == 5) ? 1 : 2;
        for (int o = 0; o < nops; o++) begin
          logic isRead, ones;
          logic [47:0] d;
          isRead = (e != 0) && (o == 0);
          ones = (e == 0) ? 1'b0 : ((o == 0) ? (e == 2 || e == 4) : (e == 1 || e == 3));
          d = ones ? ~bg : bg;
          if (!isRead) lw = d;
          expQ.push_back(opExp_t'({a, isRead, lw}));
        end
      end
    end
  endtask

  task automatic startRun(input int which, input logic [47:0] bg, input bit hold);
    sel = which;
    busyCnt = 0;
    ceCnt = 0;
    wrCnt = 0;
    pushRun(bg);
    @(negedge cclk);
    start[which] = 1'b1;
    @(posedge cclk);
    #1;
    if (!hold) start[which] = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (done[sel] !== 1'b1 && n < 4000) begin
      @(posedge cclk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = '0;
    faultMode = 0;
    sel = 0;
    repeat (3) @(posedge cclk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      applied++;
      if ({mode[i], ceN[i], weN[i], busy[i], done[i], fail[i]} !== 6'b011000) begin
        errs++;
        $display("[TB] FAIL reset_ctrl[%0d]: got %b expected 011000", i,
                 {mode[i], ceN[i], weN[i], busy[i], done[i], fail[i]});
      end
      applied++;
      if ({addr[i], wrData[i], failAddr[i], failElem[i], failBits[i]} !== '0) begin
        errs++;
        $display("[TB] FAIL reset_data[%0d]: got addr=%h wd=%h fa=%h fe=%h fb=%h expected all 0",
                 i, addr[i], wrData[i], failAddr[i], failElem[i], failBits[i]);
      end
    end
    @(negedge cclk);
    reset = 1'b0;
  endtask

  task automatic checkCleanRun(input string tag, input int n);
    applied++;
    if (n !== 2561) begin errs++; $display("[TB] FAIL %s_len: got %0d expected 2561", tag, n); end
    applied++;
    if (fail[sel] !== 1'b0) begin errs++; $display("[TB] FAIL %s_fail: got %b expected 0", tag, fail[sel]); end
    applied++;
    if (ceCnt !== 2560) begin errs++; $display("[TB] FAIL %s_ops: got %0d expected 2560", tag, ceCnt); end
    applied++;
    if (expQ.size() !== 0) begin errs++; $display("[TB] FAIL %s_left: got %0d expected 0", tag, expQ.size()); end
    expQ.delete();
  endtask

  task automatic test_clean_pass();
    int n;
    startRun(0, 48'h0, 1'b0);
    waitDone(n);
    checkCleanRun("clean", n);
    applied++;
    if (busyCnt !== 2561) begin errs++; $display("[TB] FAIL clean_busy: got %0d expected 2561", busyCnt); end
    applied++;
    if (wrCnt !== 1280) begin errs++; $display("[TB] FAIL clean_writes: got %0d expected 1280", wrCnt); end
    applied++;
    if ({mode[0], ceN[0], weN[0]} !== 3'b011) begin
      errs++;
      $display("[TB] FAIL clean_idle_pins: got %b expected 011", {mode[0], ceN[0], weN[0]});
    end
  endtask

  task automatic test_stuck_stop();
    int n;
    faultMode = 1;
    startRun(0, 48'h0, 1'b0);
    waitDone(n);
    applied++;
    if (n !== 379) begin errs++; $display("[TB] FAIL stuck_stop_len: got %0d expected 379", n); end
    applied++;
    if (ceCnt !== 378) begin errs++; $display("[TB] FAIL stuck_stop_ops: got %0d expected 378", ceCnt); end
    applied++;
    if ({fail[0], failAddr[0], failElem[0], failBits[0]} !== {1'b1, 8'h3C, 3'd1, 48'h20}) begin
      errs++;
      $display("[TB] FAIL stuck_stop_capture: got %b/%h/%0d/%h expected 1/3c/1/000000000020",
               fail[0], failAddr[0], failElem[0], failBits[0]);
    end
    expQ.delete();
  endtask

  task automatic test_stuck_nostop();
    int n;
    faultMode = 1;
    startRun(1, 48'h0, 1'b0);
    waitDone(n);
    applied++;
    if (n !== 2561) begin errs++; $display("[TB] FAIL nostop_len: got %0d expected 2561", n); end
    applied++;
    if (ceCnt !== 2560) begin errs++; $display("[TB] FAIL nostop_ops: got %0d expected 2560", ceCnt); end
    applied++;
    if ({fail[1], failAddr[1], failElem[1], failBits[1]} !== {1'b1, 8'h3C, 3'd1, 48'h20}) begin
      errs++;
      $display("[TB] FAIL nostop_capture: got %b/%h/%0d/%h expected 1/3c/1/000000000020",
               fail[1], failAddr[1], failElem[1], failBits[1]);
    end
    expQ.delete();
  endtask

  task automatic test_coupling_restart();
    int n;
    faultMode = 2;
    startRun(0, 48'h0, 1'b0);
    waitDone(n);
    applied++;
    if (n !== 769) begin errs++; $display("[TB] FAIL coupling_len: got %0d expected 769", n); end
    applied++;
    if ({fail[0], failAddr[0], failElem[0], failBits[0]} !== {1'b1, 8'hFF, 3'd1, 48'h1}) begin
      errs++;
      $display("[TB] FAIL coupling_capture: got %b/%h/%0d/%h expected 1/ff/1/000000000001",
               fail[0], failAddr[0], failElem[0], failBits[0]);
    end
    expQ.delete();
    faultMode = 0;
    startRun(0, 48'h0, 1'b0);
    applied++;
    if ({done[0], fail[0], failAddr[0], failElem[0], failBits[0]} !== '0) begin
      errs++;
      $display("[TB] FAIL restart_clear: got done=%b fail=%b fa=%h fe=%0d fb=%h expected all 0",
               done[0], fail[0], failAddr[0], failElem[0], failBits[0]);
    end
    waitDone(n);
    checkCleanRun("restart", n);
  endtask

  task automatic test_reset_midrun();
    int n;
    startRun(0, 48'h0, 1'b0);
    repeat (999) @(posedge cclk);
    #1;
    reset = 1'b1;
    @(posedge cclk);
    #1;
    applied++;
    if ({mode[0], ceN[0], weN[0], busy[0], done[0], fail[0]} !== 6'b011000) begin
      errs++;
      $display("[TB] FAIL midrun_ctrl: got %b expected 011000",
               {mode[0], ceN[0], weN[0], busy[0], done[0], fail[0]});
    end
    applied++;
    if ({addr[0], wrData[0], failAddr[0], failElem[0], failBits[0]} !== '0) begin
      errs++;
      $display("[TB] FAIL midrun_data: got addr=%h wd=%h expected 0", addr[0], wrData[0]);
    end
    expQ.delete();
    reset = 1'b0;
    startRun(0, 48'h0, 1'b0);
    waitDone(n);
    checkCleanRun("after_reset", n);
  endtask

  task automatic test_start_held();
    int n;
    startRun(2, 48'hAAAA_AAAA_AAAA, 1'b1);
    waitDone(n);
    checkCleanRun("held", n);
    applied++;
    if (busyCnt !== 2561) begin errs++; $display("[TB] FAIL held_busy: got %0d expected 2561", busyCnt); end
    busyCnt = 0;
    ceCnt = 0;
    pushRun(48'hAAAA_AAAA_AAAA);
    @(posedge cclk);
    #1;
    applied++;
    if ({done[2], busy[2], fail[2]} !== 3'b010) begin
      errs++;
      $display("[TB] FAIL held_rerun: got done/busy/fail=%b expected 010", {done[2], busy[2], fail[2]});
    end
    waitDone(n);
    start[2] = 1'b0;
    checkCleanRun("held_rerun", n);
    repeat (3) @(posedge cclk);
    #1;
    applied++;
    if ({done[2], busy[2]} !== 2'b10) begin
      errs++;
      $display("[TB] FAIL held_done_hold: got done/busy=%b expected 10", {done[2], busy[2]});
    end
  endtask

  initial begin
    applied = 0;
    errs = 0;
    busyCnt = 0;
    ceCnt = 0;
    wrCnt = 0;
    test_reset();
    test_clean_pass();
    test_stuck_stop();
    test_stuck_nostop();
    test_coupling_restart();
    test_reset_midrun();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
